disp_lr_check: RTL and testbench

- Left/right consistency checker for the SGM disparity stream.
- Consumes the per-pixel left-reference disparity (SGM core output) and the right-reference disparity, one pair per pixel enable.
- Rejects pixels whose left/right disparities disagree and hole-fills them.
- Feeds the downstream 3x3 median stage and the SPI readback mux. It also keeps a per-frame rejected-pixel count.

---
 rtl/disp_lr_check.sv | 132 +++++++++++++
 tb/tb_disp_lr_check.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/disp_lr_check.sv
// disp_lr_check -- left/right consistency check for the SGM disparity stream.
//
// Each enabled pixel carries a left-reference disparity (dispL_i) and a
// right-reference disparity (dispR_i = d). The left disparity of the pixel
// d positions back on the same line is the partner. The pixel is accepted
// when that partner exists and agrees with d to within DiffThresh.
// A rejected pixel is hole-filled, and a per-frame reject count is kept.
//
// Ports
//   clk_p     in   pixel clock
//   rst_p     in   asynchronous reset, active low
//   en_p      in   pixel enable; one disparity pair per high cycle
//   sof_i     in   start of frame, qualified by en_p (pixel is x=0, line 0)
//   dispL_i   in   left-reference disparity
//   dispR_i   in   right-reference disparity
//   disp_o    out  checked / filled disparity
//   en_o      out  one-cycle strobe, disp_o/occl_o updated
//   occl_o    out  1 = pixel rejected
//   rejCnt_o  out  reject count of the last completed frame
module disp_lr_check #(
  parameter int dispLevel  = 32,
  parameter int DispW      = 5,
  parameter int ImageW     = 640,
  parameter int DiffThresh = 4,
  parameter int FillMode   = 1,
  parameter int CntW       = 20
) (
  input  logic             clk_p,
  input  logic             rst_p,
  input  logic             en_p,
  input  logic             sof_i,
  input  logic [DispW-1:0] dispL_i,
  input  logic [DispW-1:0] dispR_i,
  output logic [DispW-1:0] disp_o,
  output logic             en_o,
  output logic             occl_o,
  output logic [CntW-1:0]  rejCnt_o
);

  localparam int XW = (ImageW > 1) ? $clog2(ImageW) : 1;
  // An accepted d is at most dispLevel-1, so it reads at most H[dispLevel-2].
  // The deepest entry can never be selected and is not stored.
  localparam int HD = (dispLevel > 2) ? dispLevel - 1 : 1;

  logic [HD-1:0][DispW-1:0] r_hist;
  logic [XW-1:0]            r_x;
  logic [DispW-1:0]         r_last;
  logic [DispW-1:0]         r_disp;
  logic                     r_en;
  logic                     r_occl;
  logic [CntW-1:0]          r_cnt;
  logic [CntW-1:0]          r_cntOut;

  logic [XW-1:0]            w_xEff;
  logic [XW-1:0]            w_xNext;
  logic [DispW-1:0]         w_lastEff;
  logic [DispW-1:0]         w_partner;
  logic [DispW-1:0]         w_fill;
  logic signed [DispW:0]    w_diff;
  logic [DispW:0]           w_abs;
  logic                     w_range;
  logic                     w_noPart;
  logic                     w_far;
  logic                     w_rej;
  logic                     w_wrap;
  logic [CntW-1:0]          w_cntInc;

  always_comb begin
    // An sof pixel is x=0 and starts with no fill value, whatever came before.
    w_xEff    = sof_i ? '0 : r_x;
    w_lastEff = sof_i ? '0 : r_last;

    // d == 0 pairs the pixel with itself; otherwise use pre-shift H[d-1].
    w_partner = dispL_i;
    for (int j = 0; j < HD; j++) begin
      if (32'(dispR_i) == 32'(j + 1)) w_partner = r_hist[j];
    end

    w_range  = 32'(dispR_i) >= 32'(dispLevel);
    // Stale history from the previous line is masked here, so no clear at wrap.
    w_noPart = 32'(dispR_i) > 32'(w_xEff);
    w_diff   = $signed({1'b0, w_partner}) - $signed({1'b0, dispR_i});
    w_abs    = w_diff[DispW] ? DispW'(-w_diff) : w_diff;
    w_far    = 32'(w_abs) >= 32'(DiffThresh);
    w_rej    = w_range | w_noPart | w_far;

    // sof wins over a natural wrap in the same cycle.
    w_wrap   = !sof_i && (r_x == XW'(ImageW - 1));
    w_xNext  = sof_i ? XW'(1) : (w_wrap ? '0 : r_x + 1'b1);

    w_fill   = (FillMode != 0) ? w_lastEff : '0;
    w_cntInc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  end

  always_ff @(posedge clk_p or negedge rst_p) begin
    if (!rst_p) begin
      r_hist   <= '0;
      r_x      <= '0;
      r_last   <= '0;
      r_disp   <= '0;
      r_en     <= 1'b0;
      r_occl   <= 1'b0;
      r_cnt    <= '0;
      r_cntOut <= '0;
    end else begin
      r_en <= en_p;
      if (en_p) begin
        r_hist[0] <= dispL_i;
        for (int j = 1; j < HD; j++) r_hist[j] <= r_hist[j-1];
        r_x    <= w_xNext;
        r_occl <= w_rej;
        r_disp <= w_rej ? w_fill : dispR_i;
        // Fill state never crosses a line boundary.
        if (w_wrap)      r_last <= '0;
        else if (!w_rej) r_last <= dispR_i;
        else             r_last <= w_lastEff;
        if (sof_i) begin
          r_cntOut <= r_cnt;
          r_cnt    <= CntW'(w_rej);
        end else if (w_rej) begin
          r_cnt <= w_cntInc;
        end
      end
    end
  end

  assign disp_o   = r_disp;
  assign en_o     = r_en;
  assign occl_o   = r_occl;
  assign rejCnt_o = r_cntOut;

endmodule

// File: tb/tb_disp_lr_check.sv
// Scoreboard bench for disp_lr_check: stimulus pushes the expected
// {disp, occl} per pixel, a negedge monitor pops on every en_o.
// The reject counter width is reduced so saturation is reachable quickly.
module tb_disp_lr_check;
  localparam int CW = 12;

  logic           clk_p = 1'b0;
  logic           rst_p = 1'b0;
  logic           en_p = 1'b0;
  logic           sof_i = 1'b0;
  logic [4:0]     dispL_i = '0;
  logic [4:0]     dispR_i = '0;
  logic [4:0]     disp_o;
  logic           en_o;
  logic           occl_o;
  logic [CW-1:0]  rejCnt_o;

  disp_lr_check #(.dispLevel(32), .DispW(5), .ImageW(640), .DiffThresh(4),
                  .FillMode(1), .CntW(CW)) dut (
    .clk_p(clk_p), .rst_p(rst_p), .en_p(en_p), .sof_i(sof_i),
    .dispL_i(dispL_i), .dispR_i(dispR_i), .disp_o(disp_o), .en_o(en_o),
    .occl_o(occl_o), .rejCnt_o(rejCnt_o));

  always #5 clk_p = ~clk_p;

  typedef struct packed {logic [4:0] d; logic o;} exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;
  bit sb_on = 1'b0;
  bit en_q  = 1'b0;
  bit have_last = 1'b0;
  logic [4:0] last_d = '0;
  logic       last_o = 1'b0;

  // Mismatch/threshold line, x = 0..25
  int t3L[26] = '{5,5,5,5,5,5,5,5,5,5,12,5,5,5,5,5,5,4,5,0,0,0,0,0,0,0};
  int t3R[26] = '{5,5,5,5,5,5,5,5,5,5,5,5,5,5,5,5,5,5,1,1,0,0,0,0,4,3};
  int t3D[26] = '{0,0,0,0,0,5,5,5,5,5,5,5,5,5,5,5,5,5,1,1,0,0,0,0,0,3};
  int t3O[26] = '{1,1,1,1,1,0,0,0,0,0,0,0,0,0,0,1,0,0,0,1,0,0,0,0,1,0};

  task automatic chk(string nm, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
    end
  endtask

  task automatic pix(bit s, int l, int r, int ed, int eo);
    exp_t e;
    @(posedge clk_p); #1;
    sof_i = s; en_p = 1'b1; dispL_i = 5'(l); dispR_i = 5'(r);
    e.d = 5'(ed); e.o = eo[0];
    q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk_p); #1;
    en_p = 1'b0; sof_i = 1'b0;
  endtask

  always @(posedge clk_p) en_q <= en_p;

  always @(negedge clk_p) begin
    if (sb_on && rst_p) begin
      chk("en_o_latency", int'(en_o), int'(en_q));
      if (en_o) begin
        if (q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("disp_o", int'(disp_o), int'(e.d));
          chk("occl_o", int'(occl_o), int'(e.o));
          last_d = e.d; last_o = e.o; have_last = 1'b1;
        end
      end else if (have_last) begin
        chk("hold_disp", int'(disp_o), int'(last_d));
        chk("hold_occl", int'(occl_o), int'(last_o));
      end
    end
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk_p);
    #1;
    chk("rst_disp", int'(disp_o), 0);
    chk("rst_en", int'(en_o), 0);
    chk("rst_occl", int'(occl_o), 0);
    chk("rst_cnt", int'(rejCnt_o), 0);
    @(posedge clk_p); #1; rst_p = 1'b1;

    // build nonzero state, then reset asynchronously mid-line
    pix(1, 3, 3, 0, 1);
    for (int i = 1; i < 5; i++) begin pix(0, 3, 3, 0, 0); idle(); end
    pix(1, 3, 3, 0, 1);
    for (int i = 1; i < 4; i++) begin pix(0, 3, 3, 0, 0); idle(); end
    pix(0, 3, 3, 0, 0);
    @(posedge clk_p); #3;
    rst_p = 1'b0;
    #1;
    chk("arst_disp", int'(disp_o), 0);
    chk("arst_en", int'(en_o), 0);
    chk("arst_occl", int'(occl_o), 0);
    chk("arst_cnt", int'(rejCnt_o), 0);
    repeat (3) begin @(posedge clk_p); #1; en_p = ~en_p; end
    @(posedge clk_p); #1;
    en_p = 1'b0; sof_i = 1'b0; rst_p = 1'b1;
    q.delete(); have_last = 1'b0; sb_on = 1'b1;

    // first pixel after reset is x=0: d=1 has no partner
    pix(0, 1, 1, 0, 1);
    pix(0, 0, 0, 0, 0);
    idle(); idle();

    // constant disparity 3 over a full line
    pix(1, 3, 3, 0, 1);
    pix(0, 3, 3, 0, 1);
    @(negedge clk_p); chk("cnt_after_reset", int'(rejCnt_o), 1);
    for (int x = 2; x < 640; x++) pix(0, 3, 3, (x < 3) ? 0 : 3, (x < 3) ? 1 : 0);

    // mismatch with fill and threshold edges
    for (int x = 0; x < 26; x++) begin
      pix(x == 0, t3L[x], t3R[x], t3D[x], t3O[x]);
      if (x == 1) begin @(negedge clk_p); chk("cnt_const3", int'(rejCnt_o), 3); end
    end
    idle(); idle(); idle();

    // lookup depth and line wrap
    for (int x = 0; x < 640; x++) begin
      if (x == 0)       pix(1, 30, 30, 0, 1);
      else if (x < 30)  pix(0, 0, 0, 0, 0);
      else if (x == 30) pix(0, 0, 31, 0, 1);
      else if (x == 31) pix(0, 0, 31, 31, 0);
      else if (x < 39)  pix(0, 7, 7, 31, 1);
      else              pix(0, 7, 7, 7, 0);
      if (x == 1) begin @(negedge clk_p); chk("cnt_mismatch", int'(rejCnt_o), 8); end
    end
    pix(0, 5, 3, 0, 1);
    pix(0, 0, 0, 0, 0);
    idle(); idle();

    // saturation: every pixel rejected
    pix(1, 0, 20, 0, 1);
    pix(0, 0, 20, 0, 1);
    @(negedge clk_p); chk("cnt_depth", int'(rejCnt_o), 10);
    for (int i = 0; i < 4200; i++) begin
      pix(0, 0, 20, 0, 1);
      if (i == 2000) begin @(negedge clk_p); chk("cnt_hold", int'(rejCnt_o), 10); end
    end
    pix(1, 0, 0, 0, 0);
    pix(0, 0, 0, 0, 0);
    @(negedge clk_p); chk("cnt_saturate", int'(rejCnt_o), (1 << CW) - 1);
    idle(); idle(); idle();
    @(negedge clk_p);
    chk("sb_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
